// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl
// Multi-level, multi-player game-flow sequencer for the VGA game top level.
// Turns button edges, a time-base strobe and player positions into the
// game_state / level / timer / freeze / players_reset controls that the
// drawing and player-movement blocks consume. All outputs are registered.
module game_flow_ctrl #(
  parameter int NUM_PLAYERS = 2,
  parameter int NUM_LEVELS  = 4,
  parameter int XPOS_W      = 12,
  parameter int FINISH_X    = 930,
  parameter int TIME_LIMIT  = 6000,
  parameter int INTER_DELAY = 200,
  localparam int LVL_W = ($clog2(NUM_LEVELS) < 1) ? 1 : $clog2(NUM_LEVELS),
  localparam int TMR_W = ($clog2(TIME_LIMIT + 1) < 1) ? 1 : $clog2(TIME_LIMIT + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          m_left,
  input  logic                          gpio,
  input  logic                          middle,
  input  logic                          tick,
  input  logic [NUM_PLAYERS*XPOS_W-1:0] xpos_players,
  output logic [2:0]                    game_state,
  output logic [LVL_W-1:0]              level,
  output logic [TMR_W-1:0]              timer,
  output logic                          freeze,
  output logic                          players_reset
);

  // Inter-level delay counter only has to reach INTER_DELAY-1.
  localparam int DLY_W = ($clog2(INTER_DELAY) < 1) ? 1 : $clog2(INTER_DELAY);

  localparam logic [LVL_W-1:0]  LVL_LAST  = LVL_W'(NUM_LEVELS - 1);
  localparam logic [LVL_W-1:0]  LVL_ONE   = LVL_W'(1);
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIME_LIMIT - 1);
  localparam logic [TMR_W-1:0]  TMR_LIMIT = TMR_W'(TIME_LIMIT);
  localparam logic [TMR_W-1:0]  TMR_ONE   = TMR_W'(1);
  localparam logic [TMR_W-1:0]  TMR_MAX   = {TMR_W{1'b1}};
  localparam logic [DLY_W-1:0]  DLY_LAST  = DLY_W'(INTER_DELAY - 1);
  localparam logic [DLY_W-1:0]  DLY_ONE   = DLY_W'(1);
  localparam logic [XPOS_W-1:0] FINISH_XV = XPOS_W'(FINISH_X);

  typedef enum logic [2:0] {
    ST_START      = 3'd0,
    ST_PLAYING    = 3'd1,
    ST_PAUSED     = 3'd2,
    ST_LEVEL_DONE = 3'd3,
    ST_FINISH     = 3'd4,
    ST_GAME_OVER  = 3'd5
  } state_t;

  state_t           r_state;
  logic [LVL_W-1:0] r_level;
  logic [TMR_W-1:0] r_timer;
  logic [DLY_W-1:0] r_dly;
  logic             r_freeze;
  logic             r_players_reset;

  // Edge-detect history; r_armed masks the first cycle after reset so a
  // button already held at reset release does not count as a press.
  logic r_armed;
  logic r_start_q;
  logic r_mid_q;

  logic w_start_lvl;
  logic w_start_ev;
  logic w_mid_ev;
  logic w_arrived;
  logic w_tmo;

  assign w_start_lvl = m_left | gpio;
  assign w_start_ev  = r_armed & w_start_lvl & ~r_start_q;
  assign w_mid_ev    = r_armed & middle & ~r_mid_q;

  // Timeout fires on the tick that would bring the timer to TIME_LIMIT.
  assign w_tmo = (TIME_LIMIT != 0) && tick && (r_timer == TMR_LAST);

  // All players must be at or beyond the finish line (unsigned compare).
  always_comb begin
    w_arrived = 1'b1;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (xpos_players[i*XPOS_W +: XPOS_W] < FINISH_XV) begin
        w_arrived = 1'b0;
      end
    end
  end

  // Register the previous button levels for rising-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_armed   <= 1'b0;
      r_start_q <= 1'b0;
      r_mid_q   <= 1'b0;
    end else begin
      r_armed   <= 1'b1;
      r_start_q <= w_start_lvl;
      r_mid_q   <= middle;
    end
  end

  // Game-flow FSM with registered level, timer, freeze and reset strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= ST_START;
      r_level         <= '0;
      r_timer         <= '0;
      r_dly           <= '0;
      r_freeze        <= 1'b1;
      r_players_reset <= 1'b0;
    end else begin
      r_players_reset <= 1'b0;
      case (r_state)
        ST_START: begin
          if (w_start_ev) begin
            r_state         <= ST_PLAYING;
            r_level         <= '0;
            r_timer         <= '0;
            r_freeze        <= 1'b0;
            r_players_reset <= 1'b1;
          end
        end

        ST_PLAYING: begin
          // Arrival beats timeout; both beat a pause request, start is ignored.
          if (w_arrived && (r_level == LVL_LAST)) begin
            r_state  <= ST_FINISH;
            r_freeze <= 1'b1;
          end else if (w_arrived) begin
            r_state  <= ST_LEVEL_DONE;
            r_dly    <= '0;
            r_freeze <= 1'b1;
          end else if (w_tmo) begin
            r_state  <= ST_GAME_OVER;
            r_timer  <= TMR_LIMIT;
            r_freeze <= 1'b1;
          end else if (w_mid_ev) begin
            r_state  <= ST_PAUSED;
            r_freeze <= 1'b1;
          end else if (tick && (r_timer != TMR_MAX)) begin
            r_timer <= r_timer + TMR_ONE;
          end
        end

        ST_PAUSED: begin
          // Timer, ticks and arrival are all frozen while paused.
          if (w_mid_ev) begin
            r_state  <= ST_PLAYING;
            r_freeze <= 1'b0;
          end
        end

        ST_LEVEL_DONE: begin
          if (tick) begin
            if (r_dly == DLY_LAST) begin
              r_state         <= ST_PLAYING;
              r_level         <= r_level + LVL_ONE;
              r_timer         <= '0;
              r_dly           <= '0;
              r_freeze        <= 1'b0;
              r_players_reset <= 1'b1;
            end else begin
              r_dly <= r_dly + DLY_ONE;
            end
          end
        end

        ST_FINISH, ST_GAME_OVER: begin
          // Final outcome holds level and timer until a restart request.
          if (w_mid_ev) begin
            r_state         <= ST_START;
            r_level         <= '0;
            r_timer         <= '0;
            r_freeze        <= 1'b1;
            r_players_reset <= 1'b1;
          end
        end

        default: begin
          r_state  <= ST_START;
          r_level  <= '0;
          r_timer  <= '0;
          r_dly    <= '0;
          r_freeze <= 1'b1;
        end
      endcase
    end
  end

  assign game_state    = r_state;
  assign level         = r_level;
  assign timer         = r_timer;
  assign freeze        = r_freeze;
  assign players_reset = r_players_reset;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed testbench for game_flow_ctrl (TIME_LIMIT=10, INTER_DELAY=200).
module tb_game_flow_ctrl;

  localparam int NP = 2;
  localparam int XW = 12;

  logic          clk;
  logic          rst;
  logic          m_left;
  logic          gpio;
  logic          middle;
  logic          tick;
  logic [NP*XW-1:0] xpos_players;
  logic [2:0]    game_state;
  logic [1:0]    level;
  logic [3:0]    timer;
  logic          freeze;
  logic          players_reset;

  int n_checks;
  int n_fail;

  game_flow_ctrl #(
    .NUM_PLAYERS(NP),
    .NUM_LEVELS (4),
    .XPOS_W     (XW),
    .FINISH_X   (930),
    .TIME_LIMIT (10),
    .INTER_DELAY(200)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .m_left       (m_left),
    .gpio         (gpio),
    .middle       (middle),
    .tick         (tick),
    .xpos_players (xpos_players),
    .game_state   (game_state),
    .level        (level),
    .timer        (timer),
    .freeze       (freeze),
    .players_reset(players_reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic set_pos(input int p1, input int p0);
    xpos_players = {XW'(p1), XW'(p0)};
  endtask

  // Drive players to the finish, then run the 200-tick hold into the next level.
  task automatic clear_level(input int next_lvl);
    set_pos(1000, 1000);
    step();
    chk("lvl_done_state", game_state, 3);
    for (int i = 0; i < 199; i++) pulse_tick();
    chk("lvl_done_hold", game_state, 3);
    set_pos(0, 0);
    pulse_tick();
    chk("next_lvl_state", game_state, 1);
    chk("next_lvl_level", level, next_lvl);
    chk("next_lvl_prst", players_reset, 1);
    step();
    chk("next_lvl_prst_end", players_reset, 0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0; m_left = 1'b0; gpio = 1'b1; middle = 1'b0; tick = 1'b0;
    set_pos(0, 0);

    // Reset held for 3 cycles with gpio already high
    repeat (3) step();
    chk("rst_state", game_state, 0);
    chk("rst_level", level, 0);
    chk("rst_timer", timer, 0);
    chk("rst_freeze", freeze, 1);
    chk("rst_prst", players_reset, 0);
    rst = 1'b1;
    step();
    step();
    chk("held_gpio_no_start", game_state, 0);
    gpio = 1'b0;
    step();

    // Test 1: single-cycle m_left press starts the game
    m_left = 1'b1;
    step();
    m_left = 1'b0;
    chk("t1_state", game_state, 1);
    chk("t1_prst", players_reset, 1);
    chk("t1_level", level, 0);
    chk("t1_freeze", freeze, 0);
    step();
    chk("t1_prst_once", players_reset, 0);

    // Test 2: arrival threshold and level advance
    set_pos(930, 929);
    step();
    chk("t2_not_arrived", game_state, 1);
    set_pos(931, 930);
    step();
    chk("t2_arrived", game_state, 3);
    chk("t2_freeze", freeze, 1);
    middle = 1'b1;
    step();
    middle = 1'b0;
    chk("t2_mid_ignored", game_state, 3);
    for (int i = 0; i < 199; i++) pulse_tick();
    chk("t2_hold199", game_state, 3);
    set_pos(0, 0);
    pulse_tick();
    chk("t2_state", game_state, 1);
    chk("t2_level", level, 1);
    chk("t2_timer", timer, 0);
    chk("t2_prst", players_reset, 1);
    step();
    chk("t2_prst_end", players_reset, 0);

    // Test 3: clear remaining levels; last arrival goes straight to FINISH
    clear_level(2);
    clear_level(3);
    set_pos(1000, 1000);
    step();
    chk("t3_finish", game_state, 4);
    chk("t3_finish_level", level, 3);
    pulse_tick();
    chk("t3_finish_timer", timer, 0);
    set_pos(0, 0);
    middle = 1'b1;
    step();
    middle = 1'b0;
    chk("t3_restart_state", game_state, 0);
    chk("t3_restart_level", level, 0);
    chk("t3_restart_prst", players_reset, 1);
    step();

    // Test 4: timeout after 10 ticks, start via gpio
    gpio = 1'b1;
    step();
    gpio = 1'b0;
    chk("t4_start", game_state, 1);
    for (int i = 0; i < 9; i++) pulse_tick();
    chk("t4_timer9", timer, 9);
    chk("t4_still_play", game_state, 1);
    pulse_tick();
    chk("t4_over", game_state, 5);
    chk("t4_timer10", timer, 10);
    repeat (3) pulse_tick();
    chk("t4_timer_hold", timer, 10);
    middle = 1'b1;
    step();
    middle = 1'b0;
    chk("t4_restart", game_state, 0);
    chk("t4_restart_timer", timer, 0);
    step();

    // Test 5: pause / resume, held middle toggles once
    m_left = 1'b1;
    step();
    m_left = 1'b0;
    for (int i = 0; i < 5; i++) pulse_tick();
    chk("t5_timer5", timer, 5);
    middle = 1'b1;
    step();
    chk("t5_paused", game_state, 2);
    chk("t5_freeze", freeze, 1);
    for (int i = 0; i < 49; i++) begin
      tick = (i < 20);
      step();
    end
    tick = 1'b0;
    chk("t5_held_once", game_state, 2);
    chk("t5_timer_frozen", timer, 5);
    middle = 1'b0;
    step();
    middle = 1'b1;
    step();
    middle = 1'b0;
    chk("t5_resumed", game_state, 1);
    chk("t5_resume_freeze", freeze, 0);
    pulse_tick();
    chk("t5_timer6", timer, 6);

    // Test 6: arrival beats timeout on the same tick; mid press dropped
    repeat (3) pulse_tick();
    chk("t6_timer9", timer, 9);
    set_pos(1000, 1000);
    middle = 1'b1;
    pulse_tick();
    middle = 1'b0;
    chk("t6_level_done", game_state, 3);
    chk("t6_level", level, 0);
    chk("t6_timer", timer, 9);
    step();
    chk("t6_mid_dropped", game_state, 3);

    // Asynchronous reset mid-cycle
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_state", game_state, 0);
    chk("arst_level", level, 0);
    chk("arst_timer", timer, 0);
    chk("arst_freeze", freeze, 1);
    chk("arst_prst", players_reset, 0);
    step();
    rst = 1'b1;
    step();
    chk("arst_released", game_state, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
